// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles framed little-endian words into
// instruction memory and releases the CPU once the frame checksum passes.
module imem_loader #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   MAX_WORDS = 64,
  parameter logic [DATAWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 mem_wen,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic [7:0]           words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_ready_q;
  logic                 mem_wen_q;
  logic [DATAWIDTH-1:0] mem_addr_q;
  logic [DATAWIDTH-1:0] mem_wdata_q;
  logic                 cpu_hold_q;
  logic                 done_q;
  logic                 err_q;
  logic [7:0]           words_q, words_d;
  logic [7:0]           cnt_lo_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [7:0]           csum_q;
  logic [1:0]           idx_q;
  logic [23:0]          word_q;
  logic [31:0]          word_d;
  logic                 xfer;
  logic                 restart;

  assign xfer    = rx_valid && rx_ready_q;
  assign restart = start &&
                   (state_q inside {IDLE, DONE, ERR});
  assign cnt_d   = {rx_data, cnt_lo_q};
  assign words_d = words_q + 8'd1;
  assign word_d  = {rx_data, word_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = HDR0;
      end
      HDR0: begin
        if (xfer) state_d = HDR1;
      end
      HDR1: begin
        if (xfer) begin
          if (cnt_d > 16'(MAX_WORDS))
            state_d = ERR;
          else if (cnt_d == 16'd0)
            state_d = CSUM;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (xfer && idx_q == 2'd3 &&
            {8'd0, words_d} == cnt_q)
          state_d = CSUM;
      end
      CSUM: begin
        if (xfer)
          state_d = (rx_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      cnt_lo_q    <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      word_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= state_d inside {HDR0, HDR1, DATA, CSUM};
      cpu_hold_q <= (state_d != DONE);
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERR);
      mem_wen_q  <= 1'b0;
      if (restart) begin
        words_q <= '0;
        csum_q  <= '0;
        idx_q   <= '0;
      end
      if (state_q == HDR0 && xfer) cnt_lo_q <= rx_data;
      if (state_q == HDR1 && xfer) cnt_q <= cnt_d;
      if (state_q == DATA && xfer) begin
        csum_q <= csum_q ^ rx_data;
        idx_q  <= idx_q + 2'd1;
        unique case (idx_q)
          2'd0: word_q[7:0]   <= rx_data;
          2'd1: word_q[15:8]  <= rx_data;
          2'd2: word_q[23:16] <= rx_data;
          default: begin
            // Write strobe fires the cycle after the lane-3 byte lands.
            mem_wen_q   <= 1'b1;
            mem_wdata_q <= DATAWIDTH'(word_d);
            mem_addr_q  <= BASE_ADDR +
                           (DATAWIDTH'(words_q) << 2);
            words_q     <= words_d;
          end
        endcase
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_wen      = mem_wen_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed frame vectors plus hand-written reset, idle-valid
// and ignored-start sequences for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [7:0]  words_loaded;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  typedef struct {
    logic [0:11][7:0] b;
    int               len;
    logic             done;
    logic             err;
    int               nw;
    logic [1:0][31:0] a;
    logic [1:0][31:0] d;
  } vec_t;

  vec_t vec[5];

  imem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wen) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      chk("send_timeout", 32'(n), 32'd0);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int k);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    chk($sformatf("v%0d_ready", k), 32'(rx_ready), 32'd1);
    chk($sformatf("v%0d_hold0", k), 32'(cpu_hold), 32'd1);
    chk($sformatf("v%0d_clr", k),
        {22'd0, load_done, load_err, words_loaded}, 32'd0);
    for (int i = 0; i < vec[k].len; i++) send(vec[k].b[i]);
    chk($sformatf("v%0d_done", k), 32'(load_done),
        32'(vec[k].done));
    chk($sformatf("v%0d_err", k), 32'(load_err),
        32'(vec[k].err));
    chk($sformatf("v%0d_hold", k), 32'(cpu_hold),
        32'(!vec[k].done));
    chk($sformatf("v%0d_rdy_end", k), 32'(rx_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_words", k), 32'(words_loaded),
        32'(vec[k].nw));
    chk($sformatf("v%0d_nwr", k), 32'(wr_addr_q.size()),
        32'(vec[k].nw));
    if (wr_addr_q.size() == vec[k].nw) begin
      for (int i = 0; i < vec[k].nw; i++) begin
        chk($sformatf("v%0d_addr%0d", k, i),
            wr_addr_q[i], vec[k].a[i]);
        chk($sformatf("v%0d_data%0d", k, i),
            wr_data_q[i], vec[k].d[i]);
      end
    end
  endtask

  initial begin
    vec[0].b   = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                   8'hB6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[0].len = 7;
    vec[0].done = 1'b1; vec[0].err = 1'b0; vec[0].nw = 1;
    vec[0].a = '{32'h0, 32'h0};
    vec[0].d = '{32'h0, 32'h00A00513};

    vec[1].b   = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
                   8'h6F, 8'hF0, 8'hDF, 8'hFF, 8'h2C, 8'h00};
    vec[1].len = 11;
    vec[1].done = 1'b1; vec[1].err = 1'b0; vec[1].nw = 2;
    vec[1].a = '{32'h4, 32'h0};
    vec[1].d = '{32'hFFDFF06F, 32'h00000093};

    vec[2] = vec[1];
    vec[2].b[10] = 8'h2D;
    vec[2].done = 1'b0; vec[2].err = 1'b1;

    vec[3].b   = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[3].len = 2;
    vec[3].done = 1'b0; vec[3].err = 1'b1; vec[3].nw = 0;
    vec[3].a = '{32'h0, 32'h0};
    vec[3].d = '{32'h0, 32'h0};

    vec[4] = vec[3];
    vec[4].b[0] = 8'h00;
    vec[4].len = 3;
    vec[4].done = 1'b1; vec[4].err = 1'b0;

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_flags", {23'd0, mem_wen, load_done, load_err,
        4'd0, 2'd0}, 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Byte offered in IDLE must not be consumed.
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_ready", 32'(rx_ready), 32'd0);
    chk("idle_done", 32'(load_done), 32'd0);
    rx_valid = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Partial frame, an ignored start, then reset mid-word.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send(8'h02);
    pulse_start();
    chk("ign_start_ready", 32'(rx_ready), 32'd1);
    send(8'h00);
    send(8'h93);
    send(8'h00);
    chk("part_words", 32'(words_loaded), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", 32'(rx_ready), 32'd0);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_flags", {30'd0, load_done, load_err}, 32'd0);
    chk("mid_addr", mem_addr, 32'd0);
    chk("mid_wdata", mem_wdata, 32'd0);
    chk("mid_words", 32'(words_loaded), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_nwr", 32'(wr_addr_q.size()), 32'd0);
    chk("mid_state_idle", 32'(rx_ready), 32'd0);

    run_vec(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the instruction memory that the CPU fetch path reads.
- Receives a framed byte stream through a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory at word-aligned byte addresses.
- Holds the CPU in reset until a frame is loaded and its checksum passes.

Parameters:
- DATAWIDTH, 32, memory data/address width; the word is fixed at 4 bytes.
- MAX_WORDS, 64, largest word count accepted (256-byte instruction memory).
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- rx_valid  input  1  a byte is present on rx_data
- rx_data  input  8  incoming byte
- rx_ready  output  1  loader accepts a byte this cycle
- mem_wen  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  DATAWIDTH  byte address of the word being written
- mem_wdata  output  DATAWIDTH  word being written, little-endian assembled
- cpu_hold  output  1  held high to keep the CPU in reset
- load_done  output  1  frame loaded and checksum passed
- load_err  output  1  frame rejected
- words_loaded  output  8  count of words written in the current frame

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, rx_ready=0, mem_wen=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, words_loaded=0.
- Frame format: CNT_LO, CNT_HI, then 4*N payload bytes (byte0 is the LSB of each word), then CSUM.
  - N = {CNT_HI, CNT_LO}.
  - CSUM = XOR of all payload bytes; it excludes the count bytes.
- Handshake: a byte transfers when rx_valid && rx_ready at a clk edge.
  - rx_ready=1 in HDR0, HDR1, DATA and CSUM; 0 otherwise.
  - There is no backpressure during write cycles.
- States and transitions:
  - IDLE: start -> HDR0; words_loaded, checksum and byte index cleared.
  - HDR0: on transfer, latch CNT_LO -> HDR1.
  - HDR1: on transfer, latch CNT_HI, then:
    - N > MAX_WORDS -> ERR
    - N == 0 -> CSUM
    - otherwise -> DATA
  - DATA: each transfer shifts the byte into the word at lane byte_idx, XORs it into the checksum, and increments byte_idx mod 4.
    - On lane 3: the next cycle drives mem_wen=1, mem_wdata=the assembled word, mem_addr=BASE_ADDR + 4*words_loaded; words_loaded increments in that same cycle.
    - The transfer that completes word N-1 -> CSUM.
  - CSUM: on transfer, received byte == checksum -> DONE, else -> ERR. The last mem_wen pulse may coincide with the first CSUM cycle.
  - DONE: load_done=1, cpu_hold=0; remains here until start.
  - ERR: load_err=1, cpu_hold=1; remains here until start.
- start in DONE or ERR:
  - clears load_done, load_err and words_loaded
  - sets cpu_hold=1 in the same edge
  - goes to HDR0
- start in HDR0, HDR1, DATA or CSUM is ignored.
- mem_wen is a single-cycle pulse. mem_addr and mem_wdata keep their last values when mem_wen=0.
- Address arithmetic is DATAWIDTH-wide and wraps modulo 2^DATAWIDTH. N never reaches the wrap because N ≤ MAX_WORDS.
- Reset mid-frame: returns to IDLE with cpu_hold=1. Words already written stay in memory and are not invalidated.
- rx_valid while rx_ready=0: the byte is not consumed, and no state changes.

Test Plan:
- Reset, then start, then stream 01 00 13 05 A0 00 B6 -> one mem_wen pulse with addr=0x0 and wdata=0x00A00513; words_loaded=1; load_done=1; cpu_hold falls to 0 the cycle after the CSUM transfer.
- start, then N=2 with words 0x00000093 and 0xFFDFF06F and the correct CSUM -> writes at 0x0 then 0x4; load_done=1.
- Same frame with CSUM XOR 0x01 -> both words written; load_err=1; cpu_hold stays 1.
- Header 41 00 (N=65 > 64) -> ERR straight after HDR1; no mem_wen; rx_ready=0.
- Header 00 00 then CSUM 00 -> DONE with no writes; a following start re-enters HDR0 with cpu_hold=1.
- rx_valid toggled randomly, plus rst asserted after 2 payload bytes -> no write for the partial word; state IDLE with all outputs at reset values. A subsequent full load then succeeds.
